// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/writeback controller for a combinational 16-bit ALU.
// Each instruction walks IDLE -> READ -> EXEC -> WB. Operands come from an
// internal register file. The ALU result and flags are committed on the edge
// that leaves EXEC, so that result, psr and the register file already hold
// the new values during the WB cycle in which done pulses.
module alu_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int WIDTH    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_c,
    input  logic [4:0]       alu_flags,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       psr,
    input  logic             ext_we,
    input  logic [3:0]       ext_addr,
    input  logic [WIDTH-1:0] ext_data,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_ASHU = 4'hC;

    // Every defined opcode except NOP and CMP produces a register result.
    function automatic logic writes_rd(input logic [3:0] op);
        return (op != OP_NOP) && (op != OP_CMP) && (op <= OP_ASHU);
    endfunction

    // Arithmetic ops (ADD/ADDU/ADDC, SUB/SUBC/CMP) are the only flag writers.
    function automatic logic writes_psr(input logic [3:0] op);
        return ((op >= 4'h5) && (op <= 4'h7)) || ((op >= 4'h9) && (op <= 4'hB));
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      instr_q, instr_d;
    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic [4:0]       psr_q, psr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic [3:0]       alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d;

    logic [3:0] op, ra, rb, rd;
    assign op = instr_q[15:12];
    assign ra = instr_q[11:8];
    assign rb = instr_q[7:4];
    assign rd = instr_q[3:0];

    // Next-state and datapath updates; ALU drive is zero outside EXEC.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        regs_d       = regs_q;
        psr_d        = psr_q;
        result_d     = result_q;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        alu_opcode_d = OP_NOP;
        alu_a_d      = '0;
        alu_b_d      = '0;
        alu_cin_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A loader write and an accept can share this edge; the
                // operand read one cycle later sees the loaded value.
                if (ext_we) begin
                    regs_d[ext_addr] = ext_data;
                end
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Operands are registered onto the ALU inputs for EXEC.
                alu_opcode_d = op;
                alu_a_d      = regs_q[ra];
                alu_b_d      = regs_q[rb];
                alu_cin_d    = psr_q[3];
                state_d      = S_EXEC;
            end
            S_EXEC: begin
                result_d  = alu_c;
                done_d    = 1'b1;
                illegal_d = (op > OP_ASHU);
                if (writes_rd(op)) begin
                    regs_d[rd] = alu_c;
                end
                if (writes_psr(op)) begin
                    psr_d = alu_flags;
                end
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, register file and registered outputs; reset discards any in-flight op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            psr_q        <= '0;
            result_q     <= '0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            alu_opcode_q <= OP_NOP;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            regs_q       <= regs_d;
            psr_q        <= psr_d;
            result_q     <= result_d;
            done_q       <= done_d;
            illegal_q    <= illegal_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cin_q    <= alu_cin_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign alu_opcode  = alu_opcode_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_cin     = alu_cin_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign result      = result_q;
    assign psr         = psr_q;
    assign dbg_data    = regs_q[dbg_addr];

endmodule
